// File: rtl/serial_adder_sub.sv
// serial_adder_sub: multi-cycle add/subtract engine.
// Walks WIDTH-bit operands DIGIT bits per clock, LSB slice first.
module serial_adder_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             carryIn,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           stateNext;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic [WIDTH-1:0] resReg;
  logic [WIDTH-1:0] resNext;
  logic [WIDTH+DIGIT-1:0] resWide;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   sliceSum;
  logic             sliceMsbCin;
  logic             lastSlice;

  // One DIGIT-wide full-adder slice plus the shifted result
  always_comb begin
    sliceSum = {1'b0, aReg[DIGIT-1:0]}
             + {1'b0, bReg[DIGIT-1:0]}
             + (DIGIT+1)'(carry);
    // Carry into the slice MSB recovered from its sum bit
    sliceMsbCin = sliceSum[DIGIT-1]
                ^ aReg[DIGIT-1]
                ^ bReg[DIGIT-1];
    resWide   = {sliceSum[DIGIT-1:0], resReg} >> DIGIT;
    resNext   = resWide[WIDTH-1:0];
    lastSlice = (cnt == CW'(N - 1));
  end

  // State register
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= stateNext;
  end

  // Next-state and handshake outputs
  always_comb begin
    stateNext = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) stateNext = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (lastSlice) stateNext = DONE;
      end
      DONE: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Operand capture, slice stepping and result registration
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      aReg     <= '0;
      bReg     <= '0;
      resReg   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      carryOut <= 1'b0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            aReg  <= A;
            bReg  <= subtract ? ~B : B;
            carry <= subtract ^ carryIn;
            cnt   <= '0;
          end
        end
        RUN: begin
          aReg   <= aReg >> DIGIT;
          bReg   <= bReg >> DIGIT;
          carry  <= sliceSum[DIGIT];
          resReg <= resNext;
          cnt    <= cnt + 1'b1;
          if (lastSlice) begin
            sum      <= resNext;
            carryOut <= sliceSum[DIGIT];
            overflow <= sliceMsbCin ^ sliceSum[DIGIT];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_sub.sv
// tb_serial_adder_sub: directed checks on three
// parameterisations of serial_adder_sub.
module tb_serial_adder_sub;

  logic clock = 1'b0;
  logic resetN = 1'b0;

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // WIDTH=1 DIGIT=1
  logic s1 = 0, sub1 = 0, c1 = 0;
  logic [0:0] a1 = '0, b1 = '0, sum1;
  logic rdy1, busy1, done1, co1, ov1;

  // WIDTH=8 DIGIT=1
  logic s8 = 0, sub8 = 0, c8 = 0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic rdy8, busy8, done8, co8, ov8;

  // WIDTH=16 DIGIT=4
  logic s16 = 0, sub16 = 0, c16 = 0;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic rdy16, busy16, done16, co16, ov16;

  serial_adder_sub #(.WIDTH(1), .DIGIT(1)) u1 (
    .clock(clock), .resetN(resetN), .start(s1),
    .subtract(sub1), .A(a1), .B(b1), .carryIn(c1),
    .ready(rdy1), .busy(busy1), .done(done1),
    .sum(sum1), .carryOut(co1), .overflow(ov1)
  );

  serial_adder_sub #(.WIDTH(8), .DIGIT(1)) u8 (
    .clock(clock), .resetN(resetN), .start(s8),
    .subtract(sub8), .A(a8), .B(b8), .carryIn(c8),
    .ready(rdy8), .busy(busy8), .done(done8),
    .sum(sum8), .carryOut(co8), .overflow(ov8)
  );

  serial_adder_sub #(.WIDTH(16), .DIGIT(4)) u16 (
    .clock(clock), .resetN(resetN), .start(s16),
    .subtract(sub16), .A(a16), .B(b16), .carryIn(c16),
    .ready(rdy16), .busy(busy16), .done(done16),
    .sum(sum16), .carryOut(co16), .overflow(ov16)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // One 8-bit operation; checks latency and results
  task automatic run8(input logic sub,
                      input logic [7:0] a,
                      input logic [7:0] b,
                      input logic cin,
                      input logic [7:0] expS,
                      input logic expC,
                      input logic expV,
                      input string tag);
    int cyc;
    @(negedge clock);
    chk({tag, "_rdy"}, 32'(rdy8), 32'd1);
    s8 = 1; sub8 = sub; a8 = a; b8 = b; c8 = cin;
    @(negedge clock);
    s8 = 0;
    cyc = 0;
    while (!done8 && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'd8);
    chk({tag, "_sum"}, 32'(sum8), 32'(expS));
    chk({tag, "_co"}, 32'(co8), 32'(expC));
    chk({tag, "_ov"}, 32'(ov8), 32'(expV));
    @(negedge clock);
    chk({tag, "_idle"}, 32'(rdy8), 32'd1);
  endtask

  initial begin
    int cyc;
    int busyCnt;
    logic [1:0] exp1;
    logic sawDone;

    // Reset state
    #3;
    chk("rst_rdy", 32'(rdy8), 32'd1);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_sum", 32'(sum8), 32'd0);
    chk("rst_co_ov", 32'({co8, ov8}), 32'd0);
    @(negedge clock);
    resetN = 1;

    // WIDTH=1: every {A,B,carryIn}
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      a1 = i[2]; b1 = i[1]; c1 = i[0];
      s1 = 1;
      @(negedge clock);
      s1 = 0;
      cyc = 0;
      while (!done1 && cyc < 20) begin
        @(negedge clock);
        cyc++;
      end
      exp1 = 2'(i[2]) + 2'(i[1]) + 2'(i[0]);
      chk($sformatf("w1_lat%0d", i), 32'(cyc), 32'd1);
      chk($sformatf("w1_res%0d", i),
          32'({co1, sum1}), 32'(exp1));
      chk($sformatf("w1_ov%0d", i),
          32'(ov1), 32'(i[0] ^ exp1[1]));
      repeat (28) @(negedge clock);
    end

    // WIDTH=8 directed
    run8(0, 8'h5A, 8'h3C, 0, 8'h96, 0, 1, "add5a3c");
    run8(0, 8'hFF, 8'h01, 0, 8'h00, 1, 0, "addff01");
    run8(1, 8'h10, 8'h20, 0, 8'hF0, 0, 0, "sub1020");
    run8(1, 8'h80, 8'h01, 0, 8'h7F, 1, 1, "sub8001");

    // WIDTH=16 DIGIT=4 with carry-in
    @(negedge clock);
    s16 = 1; a16 = 16'hFFFF; b16 = 16'h0000; c16 = 1;
    @(negedge clock);
    s16 = 0;
    cyc = 0;
    busyCnt = 0;
    forever begin
      if (busy16) busyCnt++;
      if (done16 || cyc >= 40) break;
      @(negedge clock);
      cyc++;
    end
    chk("w16_lat", 32'(cyc), 32'd4);
    chk("w16_busy", 32'(busyCnt), 32'd4);
    chk("w16_sum", 32'(sum16), 32'h0000);
    chk("w16_co", 32'(co16), 32'd1);
    chk("w16_ov", 32'(ov16), 32'd0);

    // Handshake: start pulses and operand changes in flight
    @(negedge clock);
    s8 = 1; sub8 = 0; a8 = 8'h01; b8 = 8'h02; c8 = 0;
    @(negedge clock);
    s8 = 0;
    chk("hs_rdy_run0", 32'(rdy8), 32'd0);
    @(negedge clock);
    s8 = 1; sub8 = 1; a8 = 8'hFF; b8 = 8'hFF; c8 = 1;
    @(negedge clock);
    s8 = 0; a8 = 8'hAA; b8 = 8'h55;
    chk("hs_rdy_run2", 32'(rdy8), 32'd0);
    chk("hs_sum_hold", 32'(sum8), 32'h7F);
    cyc = 2;
    while (!done8 && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
    chk("hs_lat", 32'(cyc), 32'd8);
    chk("hs_rdy_done", 32'(rdy8), 32'd0);
    chk("hs_sum", 32'(sum8), 32'h03);
    chk("hs_co_ov", 32'({co8, ov8}), 32'd0);
    s8 = 1; a8 = 8'h55; b8 = 8'h11; sub8 = 0;
    @(negedge clock);
    s8 = 0;
    chk("hs_noqueue_rdy", 32'(rdy8), 32'd1);
    chk("hs_noqueue_busy", 32'(busy8), 32'd0);
    chk("hs_sum_kept", 32'(sum8), 32'h03);

    // Asynchronous reset in the middle of RUN
    @(negedge clock);
    s8 = 1; sub8 = 0; a8 = 8'h12; b8 = 8'h34; c8 = 0;
    @(negedge clock);
    s8 = 0;
    @(negedge clock);
    @(negedge clock);
    @(posedge clock);
    #2 resetN = 0;
    #1;
    chk("ar_rdy", 32'(rdy8), 32'd1);
    chk("ar_busy", 32'(busy8), 32'd0);
    chk("ar_done", 32'(done8), 32'd0);
    chk("ar_sum", 32'(sum8), 32'd0);
    chk("ar_co_ov", 32'({co8, ov8}), 32'd0);
    @(negedge clock);
    resetN = 1;
    sawDone = 0;
    repeat (12) begin
      @(negedge clock);
      sawDone |= done8;
    end
    chk("ar_nodone", 32'(sawDone), 32'd0);
    run8(0, 8'h7F, 8'h01, 0, 8'h80, 0, 1, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
